shiftreg_arbiter: RTL and testbench

Round-robin arbiter that shares one 74hc595 byte shifter among `N_REQ` requesters, such as display, LED and status-port writers. It accepts byte requests and issues each winner's byte to the shifter through its `i_Data`/`i_Enable`/`o_Ready` handshake. It reports per-requester grant and completion, and sits between the application logic and the shifter instance.

---
 rtl/shiftreg_arbiter.sv | 178 +++++++++++++++++
 tb/tb_shiftreg_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_arbiter.sv
// shiftreg_arbiter
//   Round-robin arbiter that shares one 74hc595 byte shifter among N_REQ
//   requesters. A winner's byte is captured on grant, offered to the shifter
//   with a one-cycle enable, and completion is reported once the shifter's
//   ready flag returns high (byte latched by RCLK).
//
// Parameters
//   N_REQ          number of requesters (2..8)
//   IDX_W          owner index width (>= clog2(N_REQ))
//   TIMEOUT_CYCLES watchdog limit in clocks (only with SHREG_ARB_TIMEOUT_EN)
//
// Optional feature macro
//   SHREG_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transfer that
//                         stays in WAIT_ACK/WAIT_DONE for TIMEOUT_CYCLES
//                         clocks; when undefined the FSM waits indefinitely
//                         and o_Timeout is tied low.
//
// Ports
//   i_clk      system clock
//   i_rst_n    synchronous active-low reset
//   i_Req      level request per requester
//   i_ReqData  byte for requester k at [8k+7:8k]
//   o_Gnt      one-cycle pulse when requester k's byte is captured
//   o_Done     one-cycle pulse when requester k's byte has been latched
//   o_Busy     high whenever the FSM is not in IDLE
//   o_Owner    index of the current or last winner
//   o_Timeout  one-cycle pulse on a watchdog abort
//   o_Data     byte to the shifter
//   o_Enable   enable strobe to the shifter
//   i_Ready    ready flag from the shifter
module shiftreg_arbiter #(
  parameter int N_REQ          = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_ReqData,
  output logic [N_REQ-1:0]   o_Gnt,
  output logic [N_REQ-1:0]   o_Done,
  output logic               o_Busy,
  output logic [IDX_W-1:0]   o_Owner,
  output logic               o_Timeout,
  output logic [7:0]         o_Data,
  output logic               o_Enable,
  input  logic               i_Ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || IDX_W < $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("shiftreg_arbiter: invalid parameter combination");
  end

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;

  logic [7:0]       req_byte [N_REQ];
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] win_off_d;
  logic [IDX_W-1:0] win_idx_d;
  logic             win_vld_d;
  logic [IDX_W:0]   win_sum;
  logic [IDX_W:0]   owner_inc;
  logic [IDX_W-1:0] owner_nxt_d;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = i_ReqData[8*gi +: 8];
  end

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_rot   = N_REQ'({i_Req, i_Req} >> rr_ptr_q);
    win_off_d = '0;
    win_vld_d = 1'b0;
    // Descending scan: the last hit written is the lowest offset.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off_d = IDX_W'(k);
        win_vld_d = 1'b1;
      end
    end
    win_sum     = {1'b0, rr_ptr_q} + {1'b0, win_off_d};
    win_idx_d   = (win_sum >= N_REQ_W) ? IDX_W'(win_sum - N_REQ_W) : IDX_W'(win_sum);
    owner_inc   = {1'b0, o_Owner} + 1'b1;
    owner_nxt_d = (owner_inc >= N_REQ_W) ? '0 : IDX_W'(owner_inc);
  end

`ifdef SHREG_ARB_TIMEOUT_EN
  localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q;
`else
  assign o_Timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      o_Gnt    <= '0;
      o_Done   <= '0;
      o_Busy   <= 1'b0;
      o_Owner  <= '0;
      o_Data   <= 8'h00;
      o_Enable <= 1'b0;
`ifdef SHREG_ARB_TIMEOUT_EN
      o_Timeout <= 1'b0;
      to_cnt_q  <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      o_Gnt    <= '0;
      o_Done   <= '0;
      o_Enable <= 1'b0;
`ifdef SHREG_ARB_TIMEOUT_EN
      o_Timeout <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A low i_Ready here also covers a shifter still finishing a byte
          // that was in flight when reset was applied.
          if (i_Ready && win_vld_d) begin
            o_Data  <= req_byte[win_idx_d];
            o_Owner <= win_idx_d;
            o_Gnt   <= N_REQ'(1) << win_idx_d;
            o_Busy  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          o_Enable <= 1'b1;
          state_q  <= WAIT_ACK;
`ifdef SHREG_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        WAIT_ACK: begin
          // Shifter drops ready once it has taken the byte.
          if (!i_Ready) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_Ready) begin
            o_Done   <= N_REQ'(1) << o_Owner;
            rr_ptr_q <= owner_nxt_d;
            o_Busy   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef SHREG_ARB_TIMEOUT_EN
      // Watchdog: a normal completion in the same cycle takes priority.
      if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST && !(state_q == WAIT_DONE && i_Ready)) begin
          o_Timeout <= 1'b1;
          rr_ptr_q  <= owner_nxt_d;
          o_Busy    <= 1'b0;
          state_q   <= IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_shiftreg_arbiter.sv
module tb_shiftreg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic        tmo;
  logic [7:0]  data;
  logic        en;
  logic        sh_ready = 1'b1;

  shiftreg_arbiter #(
    .N_REQ(4),
    .IDX_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_Req(req),
    .i_ReqData(req_data),
    .o_Gnt(gnt),
    .o_Done(done),
    .o_Busy(busy),
    .o_Owner(owner),
    .o_Timeout(tmo),
    .o_Data(data),
    .o_Enable(en),
    .i_Ready(sh_ready)
  );

  always #5 clk = ~clk;

  // Behavioural 74hc595 shifter: takes a byte on enable, shifts 8 bits
  // MSB first, latches, then raises ready (held low while sh_stuck).
  int         sh_cnt = 0;
  logic [7:0] sh_shift = 8'h00;
  logic [7:0] sh_hold = 8'h00;
  logic       sh_stuck = 1'b0;
  logic       ser_q[$];
  logic [7:0] latched_q[$];

  always @(posedge clk) begin
    if (sh_cnt == 0) begin
      if (en && sh_ready) begin
        sh_shift <= data;
        sh_hold  <= data;
        sh_ready <= 1'b0;
        sh_cnt   <= 1;
      end
    end else if (sh_cnt <= 8) begin
      ser_q.push_back(sh_shift[7]);
      sh_shift <= sh_shift << 1;
      sh_cnt   <= sh_cnt + 1;
    end else if (sh_cnt == 9) begin
      latched_q.push_back(sh_hold);
      sh_cnt <= 10;
    end else if (!sh_stuck) begin
      sh_ready <= 1'b1;
      sh_cnt   <= 0;
    end
  end

  // Event counters sampled on the active edge.
  int cyc = 0, gnt_cnt = 0, done_cnt = 0, to_cnt = 0, to_cyc = 0, en_viol = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gnt != 4'b0) gnt_cnt <= gnt_cnt + 1;
    if (done != 4'b0) done_cnt <= done_cnt + 1;
    if (tmo) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (en && !sh_ready) en_viol <= en_viol + 1;
  end

  typedef struct {
    int         owner;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] lat_exp_q[$];

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int o, input logic [7:0] v);
    exp_t e;
    e.owner = o;
    e.val   = v;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},   32'(gnt),   32'h0);
    check({tag, "_done"},  32'(done),  32'h0);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_en"},    32'(en),    32'h0);
    check({tag, "_tmo"},   32'(tmo),   32'h0);
    check({tag, "_data"},  32'(data),  32'h0);
    check({tag, "_owner"}, 32'(owner), 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
  endtask

  task automatic expect_gnt(input string tag, input int max_wait);
    exp_t e;
    int   k = 0;
    while (gnt == 4'b0 && k < max_wait) begin
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    $display("grant %s: gnt=%b owner=%0d data=%02h (expect owner %0d data %02h)",
             tag, gnt, owner, data, e.owner, e.val);
    check({tag, "_gnt"},   32'(gnt),   32'(1) << e.owner);
    check({tag, "_owner"}, 32'(owner), 32'(e.owner));
    check({tag, "_data"},  32'(data),  32'(e.val));
    check({tag, "_busy"},  32'(busy),  32'h1);
    lat_exp_q.push_back(e.val);
  endtask

  task automatic check_latched(input string tag);
    logic [7:0] got;
    logic [7:0] want;
    got = 8'hzz;
    if (latched_q.size() > 0) got = latched_q.pop_front();
    want = lat_exp_q.pop_front();
    check({tag, "_latched"}, 32'(got), 32'(want));
  endtask

  task automatic expect_done(input string tag, input int o);
    int k = 0;
    while (done == 4'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    $display("done %s: done=%b busy=%b (expect owner %0d)", tag, done, busy, o);
    check({tag, "_done"}, 32'(done), 32'(1) << o);
    check({tag, "_busy_end"}, 32'(busy), 32'h0);
    check_latched(tag);
  endtask

  initial begin
    logic [7:0] ser_v;
    int         g_cyc;
    int         gc;
    int         dc;
    int         k;

    // Reset state
    @(negedge clk);
    do_reset(3);

    // Single request, byte 0xA5
    req_data = 32'h0000_00A5;
    push_exp(0, 8'hA5);
    req = 4'b0001;
    expect_gnt("single", 1);
    req = 4'b0000;
    @(negedge clk);
    check("single_en_hi", 32'(en), 32'h1);
    check("single_gnt_lo", 32'(gnt), 32'h0);
    @(negedge clk);
    check("single_en_lo", 32'(en), 32'h0);
    expect_done("single", 0);
    ser_v = 8'h00;
    check("single_ser_len", 32'(ser_q.size()), 32'd8);
    while (ser_q.size() > 0) ser_v = {ser_v[6:0], ser_q.pop_front()};
    check("single_ser_bits", 32'(ser_v), 32'hA5);

    // Four requesters held continuously: rotation 0,1,2,3,0
    @(negedge clk);
    do_reset(1);
    req_data = 32'h4433_2211;
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(2, 8'h33);
    push_exp(3, 8'h44);
    push_exp(0, 8'h11);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int o;
      o = exp_q[0].owner;
      expect_gnt("rr", 50);
      if (t == 4) req = 4'b0000;
      expect_done("rr", o);
    end

    // Shifter ready stuck low after a transfer; new requests must wait
    @(negedge clk);
    dc = done_cnt;
    sh_stuck = 1'b1;
    req_data = 32'h007E_5C60;
    push_exp(1, 8'h5C);
    req = 4'b0010;
    expect_gnt("stuck", 10);
    g_cyc = cyc;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    gc = gnt_cnt;
    req = 4'b0101;
    repeat (25) @(negedge clk);
    $display("stuck: busy=%b tmo_count=%0d grants_during=%0d", busy, to_cnt, gnt_cnt - gc);
    check("stuck_no_grant", 32'(gnt_cnt), 32'(gc));
    check("stuck_en_lo", 32'(en), 32'h0);
`ifdef SHREG_ARB_TIMEOUT_EN
    check("stuck_tmo_count", 32'(to_cnt), 32'd1);
    check("stuck_tmo_time", 32'(to_cyc - g_cyc), 32'd17);
    check("stuck_busy", 32'(busy), 32'h0);
    check("stuck_no_done", 32'(done_cnt), 32'(dc));
    sh_stuck = 1'b0;
    check_latched("stuck");
`else
    check("stuck_tmo_count", 32'(to_cnt), 32'd0);
    check("stuck_tmo", 32'(tmo), 32'h0);
    check("stuck_busy", 32'(busy), 32'h1);
    sh_stuck = 1'b0;
    expect_done("stuck", 1);
`endif
    push_exp(2, 8'h7E);
    expect_gnt("after_stuck", 50);
    req = 4'b0000;
    expect_done("after_stuck", 2);

    // Reset during WAIT_DONE with all requesting
    @(negedge clk);
    req_data = 32'hD4C3_B2A1;
    push_exp(3, 8'hD4);
    req = 4'b1111;
    expect_gnt("pre_rst", 50);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    do_reset(1);
    gc = gnt_cnt;
    dc = done_cnt;
    k = 0;
    while (!sh_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_no_grant", 32'(gnt_cnt), 32'(gc));
    check("rst_gnt_lo", 32'(gnt), 32'h0);
    check_latched("rst_aborted");
    push_exp(0, 8'hA1);
    expect_gnt("post_rst", 3);
    req = 4'b0000;
    expect_done("post_rst", 0);
    @(negedge clk);
    check("rst_done_count", 32'(done_cnt), 32'(dc + 1));

    check("en_while_not_ready", 32'(en_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
